// File: rtl/candd_source_select_if.sv
// Symbol-source bus between the demodulator/decoder streams and the clock-and-data output stage.
// master drives the source streams and controls; slave is the selector.
interface candd_source_select_if #(
  parameter int NUM_SOURCES = 8
);
  logic [3:0]               sourceSelect;
  logic [NUM_SOURCES-1:0]   srcClkEn;
  logic [3*NUM_SOURCES-1:0] srcData;
  logic                     diffDecodeEn;
  logic [15:0]              losTimeout;
  logic                     clkEnOut;
  logic [2:0]               dataOut;
  logic                     switching;
  logic                     losDetected;

  modport master (
    output sourceSelect, srcClkEn, srcData, diffDecodeEn, losTimeout,
    input  clkEnOut, dataOut, switching, losDetected
  );

  modport slave (
    input  sourceSelect, srcClkEn, srcData, diffDecodeEn, losTimeout,
    output clkEnOut, dataOut, switching, losDetected
  );
endinterface

// File: rtl/candd_source_select.sv
// Glitch-free selector of one symbol stream for the clock-and-data output stage, with
// optional differential decode of bit 0 and loss-of-clock detection on the active source.
module candd_source_select #(
  parameter int NUM_SOURCES    = 8,
  parameter int SWITCH_HOLDOFF = 64
) (
  input  logic clk,
  input  logic reset,
  candd_source_select_if.slave bus
);

  typedef enum logic [1:0] {RUN, FLUSH, ARM} state_t;

  localparam int              HW        = $clog2(SWITCH_HOLDOFF);
  localparam logic [HW-1:0]   HOLD_LAST = HW'(SWITCH_HOLDOFF - 1);
  localparam logic [4:0]      NUM_SRC   = 5'(NUM_SOURCES);

  state_t        state, stateNext;
  logic [3:0]    activeSel, activeSelNext;
  logic [3:0]    targetSel, targetSelNext;
  logic [HW-1:0] holdCnt, holdCntNext;

  logic [3:0]    selReg;
  logic          diffReg;
  logic          enReg;
  logic [2:0]    dataReg;
  logic          capEn;
  logic [2:0]    capData;
  logic          activeValid;
  logic          acceptSym;
  logic          enterRun;

  logic          clkEnReg;
  logic [2:0]    dataOutReg;
  logic          prevBit;
  logic [15:0]   losCnt;

  assign activeValid = ({1'b0, activeSel} < NUM_SRC);

  // Capture is steered by the index that will be active after this edge, so the first
  // registered enable seen in ARM already belongs to the newly selected source.
  always_comb begin
    capEn   = 1'b0;
    capData = 3'b000;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (activeSelNext == 4'(i)) begin
        capEn   = bus.srcClkEn[i];
        capData = bus.srcData[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      activeSel <= '0;
      targetSel <= '0;
      holdCnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state     <= stateNext;
      activeSel <= activeSelNext;
      targetSel <= targetSelNext;
      holdCnt   <= holdCntNext;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves a latch behind.
    stateNext     = state;
    activeSelNext = activeSel;
    targetSelNext = targetSel;
    holdCntNext   = holdCnt;
    case (state)
      RUN: begin
        if (selReg != activeSel) begin
          stateNext     = FLUSH;
          targetSelNext = selReg;
          holdCntNext   = '0;
        end
      end
      FLUSH: begin
        if (selReg != targetSel) begin
          targetSelNext = selReg;
          holdCntNext   = '0;
        end else if (holdCnt == HOLD_LAST) begin
          stateNext     = ARM;
          activeSelNext = targetSel;
        end else begin
          holdCntNext = holdCnt + HW'(1);
        end
      end
      ARM: begin
        if (selReg != targetSel) begin
          stateNext     = FLUSH;
          targetSelNext = selReg;
          holdCntNext   = '0;
        end else if (enReg || !activeValid) begin
          stateNext = RUN;
        end
      end
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    acceptSym = (state == RUN) && (selReg == activeSel) && enReg;
    enterRun  = (state == ARM) && (stateNext == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      selReg     <= '0;
      diffReg    <= 1'b0;
      enReg      <= 1'b0;
      dataReg    <= '0;
      clkEnReg   <= 1'b0;
      dataOutReg <= '0;
      prevBit    <= 1'b0;
      losCnt     <= '0;
    end else begin
      selReg   <= bus.sourceSelect;
      diffReg  <= bus.diffDecodeEn;
      enReg    <= capEn;
      dataReg  <= capData;
      clkEnReg <= acceptSym;
      if (acceptSym) begin
        dataOutReg <= {dataReg[2:1], dataReg[0] ^ (diffReg & prevBit)};
        prevBit    <= dataReg[0];
      end else if (enterRun) begin
        prevBit <= 1'b0;
      end
      if (state != RUN || enReg || bus.losTimeout == '0) begin
        losCnt <= '0;
      end else if (losCnt != 16'hFFFF) begin
        losCnt <= losCnt + 16'd1;
      end
    end
  end

  assign bus.clkEnOut    = clkEnReg;
  assign bus.dataOut     = dataOutReg;
  assign bus.switching   = (state != RUN);
  assign bus.losDetected = (state == RUN) && (bus.losTimeout != '0) && (losCnt >= bus.losTimeout);

endmodule

// File: tb/tb_candd_source_select.sv
// Self-checking bench for candd_source_select: directed scenarios plus random select/enable
// traffic, compared every cycle against a timestamp/countdown reference model.
module tb_candd_source_select;
  localparam int NS   = 8;
  localparam int HOLD = 64;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   testsRun    = 0;
  int   testsFailed = 0;

  candd_source_select_if #(.NUM_SOURCES(NS)) bus ();

  candd_source_select #(.NUM_SOURCES(NS), .SWITCH_HOLDOFF(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Stimulus configuration
  int  period  [NS];
  int  phase   [NS];
  int  fixData [NS];
  bit  srcOn   [NS];
  bit  oneShot [NS];
  bit  randMode = 1'b0;
  bit  d0Seq [$];
  int  cyc = 0;

  // Reference model: input register view plus switch bookkeeping
  logic [3:0] qSel;
  bit         qEn  [NS];
  logic [2:0] qSym [NS];
  bit         qDiff;
  int         active, target, quiet;
  bit         pending;
  bit         prevBit;
  bit         expEn;
  logic [2:0] expData;
  int         edgeNum = 0;
  int         lastRef = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    active  = 0;
    target  = 0;
    quiet   = 0;
    pending = 1'b0;
    prevBit = 1'b0;
    expEn   = 1'b0;
    expData = 3'b000;
    lastRef = edgeNum;
    qSel    = 4'd0;
    qDiff   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      qEn[i]  = 1'b0;
      qSym[i] = 3'b000;
    end
  endtask

  // One rising edge of the model, using the inputs registered at the previous edge.
  task automatic modelStep();
    bit         en;
    logic [2:0] d;
    edgeNum++;
    if (!reset) begin
      modelReset();
      return;
    end
    en    = (active < NS) ? qEn[active] : 1'b0;
    d     = (active < NS) ? qSym[active] : 3'b000;
    expEn = 1'b0;
    if (int'(qSel) != target) begin
      target  = int'(qSel);
      quiet   = HOLD;
      pending = 1'b1;
      lastRef = edgeNum;
    end else if (quiet > 0) begin
      quiet--;
      if (quiet == 0) active = target;
      lastRef = edgeNum;
    end else if (pending) begin
      if (active >= NS || en) begin
        pending = 1'b0;
        prevBit = 1'b0;
      end
      lastRef = edgeNum;
    end else begin
      if (en) begin
        expEn   = 1'b1;
        expData = {d[2:1], qDiff ? (d[0] ^ prevBit) : d[0]};
        prevBit = d[0];
      end
      if (en || bus.losTimeout == 16'd0) lastRef = edgeNum;
    end
    qSel  = bus.sourceSelect;
    qDiff = bus.diffDecodeEn;
    for (int i = 0; i < NS; i++) begin
      qEn[i]  = bus.srcClkEn[i];
      qSym[i] = bus.srcData[3*i +: 3];
    end
  endtask

  function automatic bit expLos();
    bit running;
    running = !pending && (quiet == 0);
    return running && (bus.losTimeout != 16'd0) && ((edgeNum - lastRef) >= int'(bus.losTimeout));
  endfunction

  task automatic drive();
    logic [NS-1:0]   en;
    logic [3*NS-1:0] dat;
    logic [2:0]      sym;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      en[i] = oneShot[i] ||
              (srcOn[i] && (randMode ? ($urandom_range(0, 5) == 0) : ((cyc % period[i]) == phase[i])));
      oneShot[i] = 1'b0;
      sym = (fixData[i] >= 0) ? 3'(fixData[i]) : 3'($urandom_range(0, 7));
      if (i == 3 && en[i] && d0Seq.size() > 0) sym[0] = d0Seq.pop_front();
      dat[3*i +: 3] = sym;
    end
    bus.srcClkEn = en;
    bus.srcData  = dat;
  endtask

  task automatic compareAll();
    check("clkEnOut", 32'(bus.clkEnOut), 32'(expEn));
    check("dataOut", 32'(bus.dataOut), 32'(expData));
    check("switching", 32'(bus.switching), 32'(pending || quiet > 0));
    check("losDetected", 32'(bus.losDetected), 32'(expLos()));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      modelStep();
      #1 drive();
      @(negedge clk);
      compareAll();
    end
  endtask

  // Asserts reset between edges and checks the outputs clear without waiting for a clock.
  task automatic asyncReset();
    #2 reset = 1'b0;
    modelReset();
    #1;
    check("rstClkEnOut", 32'(bus.clkEnOut), 32'd0);
    check("rstDataOut", 32'(bus.dataOut), 32'd0);
    check("rstSwitching", 32'(bus.switching), 32'd0);
    check("rstLosDetected", 32'(bus.losDetected), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      period[i]  = 10;
      phase[i]   = int'($urandom_range(0, 9));
      fixData[i] = -1;
      srcOn[i]   = 1'b1;
      oneShot[i] = 1'b0;
    end
    phase[0]   = 0;
    fixData[0] = 5;
    bus.sourceSelect = 4'd0;
    bus.diffDecodeEn = 1'b0;
    bus.losTimeout   = 16'd0;
    bus.srcClkEn     = '0;
    bus.srcData      = '0;
    modelReset();

    // Reset state, then source 0 passthrough with fixed data 3'b101
    tick(3);
    check("resetClkEnOut", 32'(bus.clkEnOut), 32'd0);
    check("resetSwitching", 32'(bus.switching), 32'd0);
    reset = 1'b1;
    tick(60);

    // Switch 0 -> 3 while both sources are live
    bus.sourceSelect = 4'd3;
    tick(150);

    // Differential decode with a known bit-0 sequence on source 3
    bus.diffDecodeEn = 1'b1;
    d0Seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tick(60);
    bus.diffDecodeEn = 1'b0;

    // Loss of clock: silence, single pulse recovery, then detection disabled
    bus.losTimeout = 16'd100;
    srcOn[3] = 1'b0;
    tick(150);
    oneShot[3] = 1'b1;
    tick(30);
    bus.losTimeout = 16'd0;
    tick(200);
    bus.losTimeout = 16'd100;
    srcOn[3] = 1'b1;
    tick(50);

    // Invalid index: no enables ever, LOS fires after the timeout in RUN
    bus.sourceSelect = 4'd12;
    tick(250);

    // Select churn inside the holdoff, then reset while waiting in ARM
    srcOn[1] = 1'b0;
    bus.sourceSelect = 4'd1;
    tick(20);
    bus.sourceSelect = 4'd2;
    tick(20);
    bus.sourceSelect = 4'd1;
    tick(75);
    check("midArmSwitching", 32'(bus.switching), 32'd1);
    asyncReset();
    tick(2);
    reset = 1'b1;
    bus.sourceSelect = 4'd0;
    srcOn[1] = 1'b1;
    tick(40);

    // Random traffic, select changes and thresholds
    randMode = 1'b1;
    for (int r = 0; r < 40; r++) begin
      bus.sourceSelect = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15))
                                                     : 4'($urandom_range(0, 7));
      bus.diffDecodeEn = 1'($urandom_range(0, 1));
      bus.losTimeout   = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(5, 40));
      tick(int'($urandom_range(10, 140)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/candd_source_select.md
Name: candd_source_select

Overview:
- Upstream neighbour of the clock-and-data output stage: it produces that stage's clock-enable input and its 3-bit data input.
- Selects one of NUM_SOURCES demodulator/decoder symbol streams (each a clock-enable plus a 3-bit symbol) using the output stage's 4-bit source select.
- Switches sources glitch-free, so the downstream jitter FIFO and DLL never see a partial or merged symbol stream.
- Applies optional differential decoding on bit 0 and flags loss of clock on the active source.

Parameters:
NUM_SOURCES, 8, number of selectable streams (1..16).
SWITCH_HOLDOFF, 64, clocks of forced enable silence after a source change (>=2).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
sourceSelect  in  4  requested source index; quasi-static, may change at any time.
srcClkEn  in  NUM_SOURCES  per-source symbol enable, one clk wide.
srcData  in  3*NUM_SOURCES  per-source symbol; source n occupies bits [3n+2:3n].
diffDecodeEn  in  1  1 = differentially decode bit 0 of the output symbol.
losTimeout  in  16  loss-of-clock threshold in clks; 0 disables detection.
clkEnOut  out  1  selected symbol enable, to the output stage's clock-enable input.
dataOut  out  3  selected symbol, to the output stage's data input.
switching  out  1  high while a source change is in progress.
losDetected  out  1  loss of clock on the active source.

Behaviour:
- Reset (reset=0, asynchronous):
  - clkEnOut=0, dataOut=0, switching=0, losDetected=0.
  - activeSel=0; state=RUN; holdoff counter=0; LOS counter=0; diff history bit=0.
  - First clock after release: if sourceSelect!=0, the normal switch sequence runs.
- Input register (every clk): sourceSelect, diffDecodeEn and the selected source's srcClkEn/srcData are captured. The data path is indexed by activeSel, never by raw sourceSelect.
- Invalid index: a registered sourceSelect >= NUM_SOURCES is treated as "no source". No enables are produced in any state.
- States:
  - RUN: clkEnOut = registered enable of activeSel. If registered sourceSelect != activeSel, go to FLUSH the same cycle that mismatch is seen, and suppress the enable in that cycle.
  - FLUSH: clkEnOut forced 0; holdoff counter counts SWITCH_HOLDOFF clks. At terminal count, load activeSel = registered sourceSelect and go to ARM.
  - ARM: clkEnOut forced 0 until the first registered enable from the new activeSel. That enable is discarded, so the first output symbol is a complete one. Go to RUN on the next cycle.
  - A select change during FLUSH or ARM restarts FLUSH with the holdoff counter cleared.
- switching: 1 in FLUSH and ARM, 0 in RUN.
- Latency in RUN: srcClkEn/srcData to clkEnOut/dataOut is exactly 2 clks (input register + output register).
- Output data: dataOut updates only when clkEnOut=1 and holds between enables. clkEnOut is a single-cycle pulse mirroring the input pulse pattern; it is never stretched or merged.
- Differential decode (diffDecodeEn=1):
  - dataOut[0] = d0 XOR prev, where prev is the d0 of the previous accepted symbol. prev updates on every accepted symbol.
  - Bits [2:1] pass unchanged.
  - prev is cleared to 0 on entry to RUN.
  - With diffDecodeEn=0, all bits pass through; prev still tracks d0.
- LOS counter:
  - Counts clks since the last registered enable of activeSel, in RUN only; saturates at 0xFFFF.
  - Cleared on each enable, on entering RUN, and while losTimeout=0.
  - losDetected=1 when count >= losTimeout and losTimeout!=0.
  - losDetected clears in the clk after the next enable, and is forced 0 in FLUSH/ARM.
  - An invalid index in RUN asserts losDetected after losTimeout clks.
- Simultaneous events: a select change and an enable in the same RUN cycle → the change wins and the enable is dropped.
- Reset mid-switch: returns immediately to RUN with activeSel=0.

Test Plan:
- Reset release, sourceSelect=0, source 0 pulses every 10 clks with data 3'b101 → clkEnOut pulses 2 clks after each input pulse, dataOut=3'b101, switching=0.
- Change select 0→3 while both sources are active (period 10) → switching=1 for 64 clks plus the wait for and discard of source 3's first pulse; zero clkEnOut pulses in that window; then source 3 symbols with 2-clk latency.
- diffDecodeEn=1, source d0 sequence 1,1,0,0,1 → dataOut[0] = 1,0,1,0,1; bits [2:1] unchanged.
- losTimeout=100, stop source pulses → losDetected rises exactly 100 clks after the last registered enable; one new pulse → losDetected falls the next clk; losTimeout=0 → never asserts.
- sourceSelect=12 with NUM_SOURCES=8 → clkEnOut stays 0 indefinitely after the switch; losDetected asserts after losTimeout clks in RUN.
- Toggle select 1→2→1 within the 64-clk holdoff, then assert reset mid-ARM → holdoff restarts on each change; the reset immediately forces all outputs to 0 and activeSel=0.
